// File: rtl/gaussian_filter_5x5_pkg.sv
// Shared constants, coefficient table, types and weighted-sum helpers
// for the 5x5 Gaussian smoothing engine.
package gauss_pkg;

  localparam int unsigned IMG_W = 256;
  localparam int unsigned IMG_H = 256;
  localparam int unsigned CW    = 10;
  localparam int unsigned PW    = 8;
  localparam int unsigned TAPS  = 5;
  localparam int unsigned KW    = 3;
  localparam int unsigned VW    = 12;  // one weighted column: 16*255
  localparam int unsigned AW    = 16;
  localparam int unsigned RND   = 128;
  localparam int unsigned SHIFT = 8;

  localparam int unsigned COEF [TAPS] = '{1, 4, 6, 4, 1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // column[r], r = 0 is the top row (y-2); window[c], c = 0 is the leftmost column (x-2)
  typedef logic [TAPS-1:0][PW-1:0] column_t;
  typedef column_t [TAPS-1:0]      window_t;
  typedef logic [TAPS-1:0][VW-1:0] vsum_t;

  function automatic logic [VW-1:0] col_sum(input column_t col);
    logic [VW-1:0] s;
    s = '0;
    for (int i = 0; i < TAPS; i++) s = s + VW'(COEF[i]) * VW'(col[i]);
    return s;
  endfunction

  function automatic logic [AW-1:0] row_sum(input vsum_t v);
    logic [AW-1:0] s;
    s = '0;
    for (int i = 0; i < TAPS; i++) s = s + AW'(COEF[i]) * AW'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/gaussian_filter_5x5_if.sv
// Source/destination image buffer ports of the Gaussian engine.
interface gaussian_filter_5x5_if;
  import gauss_pkg::*;

  logic          imgs_rd_en;
  logic [CW-1:0] imgs_rd_px;
  logic [CW-1:0] imgs_rd_py;
  logic [PW-1:0] imgs_rd_dt;
  logic          imgs_rd_vl;
  logic          imgd_rd_en;
  logic [CW-1:0] imgd_rd_px;
  logic [CW-1:0] imgd_rd_py;
  logic [PW-1:0] imgd_rd_dt;
  logic          imgd_rd_vl;
  logic          imgd_wr_en;
  logic [CW-1:0] imgd_wr_px;
  logic [CW-1:0] imgd_wr_py;
  logic [PW-1:0] imgd_wr_dt;

  modport master (
    output imgs_rd_en, imgs_rd_px, imgs_rd_py,
    input  imgs_rd_dt, imgs_rd_vl,
    output imgd_rd_en, imgd_rd_px, imgd_rd_py,
    input  imgd_rd_dt, imgd_rd_vl,
    output imgd_wr_en, imgd_wr_px, imgd_wr_py, imgd_wr_dt
  );

  modport slave (
    input  imgs_rd_en, imgs_rd_px, imgs_rd_py,
    output imgs_rd_dt, imgs_rd_vl,
    input  imgd_rd_en, imgd_rd_px, imgd_rd_py,
    output imgd_rd_dt, imgd_rd_vl,
    input  imgd_wr_en, imgd_wr_px, imgd_wr_py, imgd_wr_dt
  );

endinterface

// File: rtl/gaussian_filter_5x5_mac.sv
// Separable 5x5 Gaussian MAC: vertical column sums, then horizontal sum with
// rounding. Two register stages from window to result.
module gauss_kernel_5x5_mac
  import gauss_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  window_t       win,
  output logic [PW-1:0] res
);

  vsum_t         vsum_q;
  logic [AW-1:0] acc_c;

  always_ff @(posedge clk or negedge rst_n) begin : vsum_p
    if (!rst_n) begin
      vsum_q <= '0;
    end else begin
      for (int c = 0; c < TAPS; c++) vsum_q[c] <= col_sum(win[c]);
    end
  end

  // Peak is 65280 + 128, so the 16-bit sum never wraps.
  assign acc_c = row_sum(vsum_q) + AW'(RND);

  always_ff @(posedge clk or negedge rst_n) begin : res_p
    if (!rst_n) res <= '0;
    else        res <= PW'(acc_c >> SHIFT);
  end

endmodule

// File: rtl/gaussian_filter_5x5.sv
// Frame-level 5x5 Gaussian filter: issues column reads, shifts returned
// pixels into a 5x5 window, and writes one filtered pixel per centre.
module gaussian_filter_5x5 #(
  parameter int unsigned IMG_W = gauss_pkg::IMG_W,
  parameter int unsigned IMG_H = gauss_pkg::IMG_H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic finish,
  gaussian_filter_5x5_if.master img
);
  import gauss_pkg::*;

  localparam int unsigned NCOL = IMG_W + 4;
  localparam int unsigned XW   = $clog2(NCOL);
  localparam int unsigned YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_e state, state_n;
  logic   start_acc_c, last_wr_c;
  logic   finish_q;

  logic          iss_busy;
  logic [XW-1:0] iss_col;
  logic [KW-1:0] iss_k;
  logic [YW-1:0] iss_row;
  logic          rd_en_q;
  logic [CW-1:0] rd_px_q, rd_py_q;

  logic [XW-1:0]            ret_col;
  logic [KW-1:0]            ret_k;
  logic [YW-1:0]            ret_row;
  logic [TAPS-2:0][PW-1:0]  col_buf;
  window_t                  win;
  logic                     win_vl;
  logic [XW-1:0]            win_x;
  logic [YW-1:0]            win_y;

  logic          d1_vl;
  logic [XW-1:0] d1_x;
  logic [YW-1:0] d1_y;
  logic          wr_en_q;
  logic [CW-1:0] wr_px_q, wr_py_q;
  logic [PW-1:0] mac_res;
  logic          unused_rd;

  assign last_wr_c = wr_en_q && (wr_px_q == CW'(IMG_W - 1)) && (wr_py_q == CW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin : state_p
    if (!rst_n) begin
      state    <= IDLE;
      finish_q <= 1'b0;
    end else begin
      state    <= state_n;
      finish_q <= (state_n == DONE);
    end
  end

  always_comb begin : next_p
    state_n     = state;
    start_acc_c = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n     = RUN;
        start_acc_c = 1'b1;
      end
      RUN:     if (last_wr_c) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Read address generator: per row, columns -2..IMG_W+1, five rows each, no bubbles.
  always_ff @(posedge clk or negedge rst_n) begin : issue_p
    if (!rst_n) begin
      iss_busy <= 1'b0;
      iss_col  <= '0;
      iss_k    <= '0;
      iss_row  <= '0;
      rd_en_q  <= 1'b0;
      rd_px_q  <= '0;
      rd_py_q  <= '0;
    end else begin
      rd_en_q <= 1'b0;
      if (start_acc_c) begin
        iss_busy <= 1'b1;
        iss_col  <= '0;
        iss_k    <= '0;
        iss_row  <= '0;
      end else if (state == RUN && iss_busy) begin
        rd_en_q <= 1'b1;
        rd_px_q <= CW'(iss_col) - CW'(2);
        rd_py_q <= CW'(iss_row) + CW'(iss_k) - CW'(2);
        if (iss_k == KW'(TAPS - 1)) begin
          iss_k <= '0;
          if (iss_col == XW'(NCOL - 1)) begin
            iss_col <= '0;
            if (iss_row == YW'(IMG_H - 1)) iss_busy <= 1'b0;
            else                           iss_row  <= iss_row + YW'(1);
          end else begin
            iss_col <= iss_col + XW'(1);
          end
        end else begin
          iss_k <= iss_k + KW'(1);
        end
      end
    end
  end

  // Valid-driven window shifter; returned data follows issue order.
  always_ff @(posedge clk or negedge rst_n) begin : window_p
    if (!rst_n) begin
      ret_col <= '0;
      ret_k   <= '0;
      ret_row <= '0;
      col_buf <= '0;
      win     <= '0;
      win_vl  <= 1'b0;
      win_x   <= '0;
      win_y   <= '0;
    end else begin
      win_vl <= 1'b0;
      if (start_acc_c) begin
        ret_col <= '0;
        ret_k   <= '0;
        ret_row <= '0;
      end else if (state == RUN && img.imgs_rd_vl) begin
        if (ret_k == KW'(TAPS - 1)) begin
          ret_k <= '0;
          win   <= {column_t'({img.imgs_rd_dt, col_buf}), win[TAPS-1:1]};
          // Column ret_col-2 completes the window centred four columns back.
          if (ret_col >= XW'(TAPS - 1)) begin
            win_vl <= 1'b1;
            win_x  <= ret_col - XW'(TAPS - 1);
            win_y  <= ret_row;
          end
          if (ret_col == XW'(NCOL - 1)) begin
            ret_col <= '0;
            ret_row <= ret_row + YW'(1);
          end else begin
            ret_col <= ret_col + XW'(1);
          end
        end else begin
          col_buf[ret_k[1:0]] <= img.imgs_rd_dt;
          ret_k               <= ret_k + KW'(1);
        end
      end
    end
  end

  gauss_kernel_5x5_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .win   (win),
    .res   (mac_res)
  );

  // Write-address delay line matched to the two MAC stages.
  always_ff @(posedge clk or negedge rst_n) begin : wr_p
    if (!rst_n) begin
      d1_vl   <= 1'b0;
      d1_x    <= '0;
      d1_y    <= '0;
      wr_en_q <= 1'b0;
      wr_px_q <= '0;
      wr_py_q <= '0;
    end else begin
      d1_vl   <= win_vl;
      d1_x    <= win_x;
      d1_y    <= win_y;
      wr_en_q <= d1_vl;
      wr_px_q <= CW'(d1_x);
      wr_py_q <= CW'(d1_y);
    end
  end

  assign finish         = finish_q;
  assign img.imgs_rd_en = rd_en_q;
  assign img.imgs_rd_px = rd_px_q;
  assign img.imgs_rd_py = rd_py_q;
  assign img.imgd_rd_en = 1'b0;
  assign img.imgd_rd_px = '0;
  assign img.imgd_rd_py = '0;
  assign img.imgd_wr_en = wr_en_q;
  assign img.imgd_wr_px = wr_px_q;
  assign img.imgd_wr_py = wr_py_q;
  assign img.imgd_wr_dt = mac_res;

  assign unused_rd = ^{img.imgd_rd_dt, img.imgd_rd_vl};

endmodule

// File: tb/tb_gaussian_filter_5x5.sv
// Scoreboard bench for gaussian_filter_5x5 on a reduced 32x16 frame with a
// clamping source buffer of programmable read latency.
module tb_gaussian_filter_5x5;

  localparam int W     = 32;
  localparam int H     = 16;
  localparam int CW    = 10;
  localparam int LIMIT = 6000;
  localparam int KC [5] = '{1, 4, 6, 4, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic finish;

  gaussian_filter_5x5_if img ();

  gaussian_filter_5x5 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .finish (finish),
    .img    (img)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; logic [7:0] d; } wr_t;
  typedef struct { logic vl; logic [7:0] dt; } rsp_t;

  logic [7:0] src     [H][W];
  logic [7:0] out_img [H][W];
  wr_t  exp_q [$];
  rsp_t pipe  [$];
  int   lat = 2;
  int   n_chk = 0, n_fail = 0;
  int   rd_cnt = 0, wr_cnt = 0, rd_en_bad = 0;
  logic [CW-1:0] first_px, first_py;
  logic prev_fin = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    int xc, yc;
    xc = (x < 0) ? 0 : ((x >= W) ? W - 1 : x);
    yc = (y < 0) ? 0 : ((y >= H) ? H - 1 : y);
    return src[yc][xc];
  endfunction

  // Reference: direct 2D weighted sum over a clamped neighbourhood.
  function automatic logic [7:0] ref_px(input int x, input int y);
    int acc = 0;
    for (int j = -2; j <= 2; j++)
      for (int i = -2; i <= 2; i++)
        acc += KC[i+2] * KC[j+2] * int'(pix(x + i, y + j));
    return 8'((acc + 128) / 256);
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({finish, img.imgs_rd_en, img.imgs_rd_px, img.imgs_rd_py, img.imgd_rd_en,
                img.imgd_wr_en, img.imgd_wr_px, img.imgd_wr_py, img.imgd_wr_dt});
  endfunction

  // Source image buffer with fixed read latency 'lat'.
  always @(negedge clk) begin
    rsp_t r;
    if (!rst_n) begin
      pipe.delete();
      img.imgs_rd_vl = 1'b0;
      img.imgs_rd_dt = 8'h00;
    end else begin
      r.vl = img.imgs_rd_en;
      r.dt = img.imgs_rd_en ? pix(int'($signed(img.imgs_rd_px)), int'($signed(img.imgs_rd_py))) : 8'h00;
      pipe.push_back(r);
      img.imgs_rd_vl = 1'b0;
      while (pipe.size() >= lat) begin
        r = pipe.pop_front();
        img.imgs_rd_vl = r.vl;
        img.imgs_rd_dt = r.dt;
      end
    end
  end

  // Monitor: scoreboard for writes, protocol bookkeeping for reads and finish.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      prev_fin = 1'b0;
    end else begin
      if (img.imgd_rd_en !== 1'b0) rd_en_bad++;
      if (img.imgs_rd_en) begin
        if (rd_cnt == 0) begin
          first_px = img.imgs_rd_px;
          first_py = img.imgs_rd_py;
        end
        rd_cnt++;
      end
      if (img.imgd_wr_en) begin
        wr_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got (%0d,%0d)=%0d expected no write",
                   img.imgd_wr_px, img.imgd_wr_py, img.imgd_wr_dt);
        end else begin
          e = exp_q.pop_front();
          if (int'(img.imgd_wr_px) != e.x || int'(img.imgd_wr_py) != e.y || img.imgd_wr_dt !== e.d) begin
            n_fail++;
            $display("FAIL wr_pixel: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                     img.imgd_wr_px, img.imgd_wr_py, img.imgd_wr_dt, e.x, e.y, e.d);
          end
          if (int'(img.imgd_wr_px) < W && int'(img.imgd_wr_py) < H)
            out_img[img.imgd_wr_py][img.imgd_wr_px] = img.imgd_wr_dt;
        end
      end
      if (finish && !prev_fin) chk("finish_after_last_write", 64'(wr_cnt), 64'(W * H));
      prev_fin = finish;
    end
  end

  task automatic load_expected();
    wr_t e;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.x = x; e.y = y; e.d = ref_px(x, y);
        exp_q.push_back(e);
        out_img[y][x] = 8'hEE;
      end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_frame(input bit poke);
    int cyc;
    load_expected();
    rd_cnt = 0;
    wr_cnt = 0;
    pulse_start();
    chk("finish_cleared", 64'(finish), 64'd0);
    cyc = 0;
    while (!finish && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 500) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk("frame_done", 64'(finish), 64'd1);
    chk("write_count", 64'(wr_cnt), 64'(W * H));
    chk("read_count", 64'(rd_cnt), 64'((W + 4) * 5 * H));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("first_read_xy", 64'({first_px, first_py}), 64'({10'h3FE, 10'h3FE}));
    repeat (10) @(negedge clk);
    chk("finish_held", 64'(finish), 64'd1);
  endtask

  task automatic fill_impulse();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) src[y][x] = 8'h00;
    src[8][16] = 8'hFF;
  endtask

  task automatic impulse_checks();
    chk("imp_centre", 64'(out_img[8][16]), 64'd36);
    chk("imp_x_m1",   64'(out_img[8][15]), 64'd24);
    chk("imp_x_m2",   64'(out_img[8][14]), 64'd6);
    chk("imp_corner", 64'(out_img[6][14]), 64'd1);
    chk("imp_x_p3",   64'(out_img[8][19]), 64'd0);
  endtask

  initial begin
    int cyc;
    img.imgd_rd_dt = 8'h00;
    img.imgd_rd_vl = 1'b0;
    fill_impulse();
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_reads", 64'(rd_cnt), 64'd0);
    chk("idle_finish_low", 64'(finish), 64'd0);

    lat = 2; run_frame(1'b0); impulse_checks();
    lat = 1; run_frame(1'b0); impulse_checks();
    lat = 3; run_frame(1'b1); impulse_checks();

    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) src[y][x] = 8'(x);
    lat = 4; run_frame(1'b0);
    chk("ramp_interior", 64'(out_img[5][10]), 64'd10);

    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) src[y][x] = 8'h80;
    lat = 2; run_frame(1'b0);
    chk("const_interior", 64'(out_img[7][20]), 64'h80);

    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) src[y][x] = 8'($urandom_range(0, 255));
    lat = 3; run_frame(1'b0);
    run_frame(1'b0);

    // Abort mid-row 10 with an asynchronous reset.
    load_expected();
    rd_cnt = 0;
    wr_cnt = 0;
    pulse_start();
    cyc = 0;
    while (wr_cnt < W * 10 + 3 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_row10", 64'(wr_cnt >= W * 10 + 3), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 chk("reset_midframe_outputs", out_vec(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    repeat (30) @(negedge clk);
    chk("no_write_after_reset", 64'(wr_cnt), 64'd0);
    chk("finish_low_after_reset", 64'(finish), 64'd0);

    lat = 1; run_frame(1'b0);
    chk("imgd_rd_en_never", 64'(rd_en_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
